// File: rtl/db_pkg.sv
// db_pkg: shared types and helpers for the multi-channel debouncer.
//   db_state_t  - per-channel qualification FSM state
//   cnt_width() - width of the stable-sample counter for a given threshold
package db_pkg;

  typedef enum logic [1:0] {
    LO,
    WAIT_HI,
    HI,
    WAIT_LO
  } db_state_t;

  // Counter must hold values up to n without wrapping.
  function automatic int unsigned cnt_width(int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/db_multi_if.sv
// db_multi_if: switch-side bundle for db_multi.
//   sw   - raw asynchronous switch inputs (driven by the board/master side)
//   db   - debounced registered levels
//   rise - one-cycle pulse on a committed 0->1
//   fall - one-cycle pulse on a committed 1->0
interface db_multi_if #(
  parameter int unsigned N_CH = 4
);

  logic [N_CH-1:0] sw;
  logic [N_CH-1:0] db;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;

  modport master (
    output sw,
    input  db,
    input  rise,
    input  fall
  );

  modport slave (
    input  sw,
    output db,
    output rise,
    output fall
  );

endinterface

// File: rtl/db_chan.sv
// db_chan: one debounce channel.
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   tick - sample enable; FSM and counter advance only when high
//   sw   - raw asynchronous switch input
//   db   - registered debounced level
//   rise - one-cycle pulse when db commits 0->1
//   fall - one-cycle pulse when db commits 1->0
// A new level commits after STABLE_CYC consecutive identical samples of the
// synchronised input; any sample of the old level restarts qualification.
module db_chan
  import db_pkg::*;
#(
  parameter int unsigned STABLE_CYC  = 20,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sw,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = cnt_width(STABLE_CYC);
  localparam logic [CntW-1:0] Last = CntW'(STABLE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  db_state_t              state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   db_d, rise_d, fall_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LO;
      cnt_q   <= '0;
      db      <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db      <= db_d;
      rise    <= rise_d;
      fall    <= fall_d;
    end
  end

  // Next state. Entering a WAIT state already counts the first new-level
  // sample, so the commit happens on the STABLE_CYC-th consecutive sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick) begin
      unique case (state_q)
        LO: begin
          if (s) begin
            state_d = WAIT_HI;
            cnt_d   = CntW'(1);
          end
        end
        WAIT_HI: begin
          if (!s) begin
            state_d = LO;
            cnt_d   = '0;
          end else if (cnt_q == Last) begin
            state_d = HI;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        HI: begin
          if (!s) begin
            state_d = WAIT_LO;
            cnt_d   = CntW'(1);
          end
        end
        WAIT_LO: begin
          if (s) begin
            state_d = HI;
            cnt_d   = '0;
          end else if (cnt_q == Last) begin
            state_d = LO;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          state_d = LO;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs: level follows the committed state, strobes mark the commit edge.
  always_comb begin
    db_d   = (state_d == HI) || (state_d == WAIT_LO);
    rise_d = tick && (state_q == WAIT_HI) && s && (cnt_q == Last);
    fall_d = tick && (state_q == WAIT_LO) && !s && (cnt_q == Last);
  end

endmodule

// File: rtl/db_multi.sv
// db_multi: N_CH-channel switch debouncer.
//   clk - system clock
//   rst - asynchronous active-low reset
//   bus - db_multi_if slave: sw in; db, rise, fall out
// Optional macro DB_TICK_EN: when defined, a free-running divider issues a
// sample tick every TICK_DIV clocks and STABLE_CYC counts ticks; otherwise
// every clock is a sample and TICK_DIV is only range-checked.
module db_multi
  import db_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned STABLE_CYC  = 20,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TICK_DIV    = 10
) (
  input  logic        clk,
  input  logic        rst,
  db_multi_if.slave   bus
);

  if (STABLE_CYC < 2 || SYNC_STAGES < 2 || TICK_DIV < 2) begin : g_param_err
    $error("db_multi: STABLE_CYC, SYNC_STAGES and TICK_DIV must be >= 2");
  end

  logic tick;

`ifdef DB_TICK_EN
  localparam int unsigned DivW = $clog2(TICK_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);

  logic [DivW-1:0] div_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
    end else if (div_q == DivLast) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DivW'(1);
    end
  end

  assign tick = (div_q == DivLast);
`else
  assign tick = 1'b1;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    db_chan #(
      .STABLE_CYC  (STABLE_CYC),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .sw   (bus.sw[i]),
      .db   (bus.db[i]),
      .rise (bus.rise[i]),
      .fall (bus.fall[i])
    );
  end

endmodule
